// File: rtl/enable_comparator_pkg.sv
// enable_comparator_pkg: mode encoding shared by the multi-channel enable comparator
package enable_comparator_pkg;
    localparam int ENCMP_MODE_WIDTH = 2;
    typedef enum logic [ENCMP_MODE_WIDTH-1:0] {
        ENCMP_OFF,
        ENCMP_PULSE,
        ENCMP_CLOCK,
        ENCMP_WINDOW
    } encmp_mode_e;
endpackage

// File: rtl/enable_channel.sv
// enable_channel: set/clear logic and pulse down-counter for one enable output
module enable_channel
    import enable_comparator_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [CW-1:0] count,
    input  logic [CW-1:0] thr,
    input  logic [CW-1:0] width,
    input  encmp_mode_e   mode,
    input  logic          mode_change,
    output logic          enable
);
    logic [CW-1:0] pulse_cnt;
    logic [CW-1:0] thr_m1;
    logic [CW-1:0] wid_m1;
    logic active;
    logic set_hit;
    logic clr_hit;
    always_comb begin
        thr_m1 = thr - CW'(1);
        wid_m1 = width - CW'(1);
        active = thr != '0;
        set_hit = active && count == thr_m1;
        clr_hit = mode == ENCMP_PULSE  ? pulse_cnt == CW'(1) :
                  mode == ENCMP_CLOCK  ? count == (thr_m1 >> 1) :
                  mode == ENCMP_WINDOW ? width != '0 && count == wid_m1 : 1'b0;
    end
    // An inactive channel (thr==0) freezes both output and counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable <= 1'b0;
            pulse_cnt <= '0;
        end else if (mode_change || mode == ENCMP_OFF) begin
            enable <= 1'b0;
            pulse_cnt <= '0;
        end else if (active) begin
            if (set_hit) begin
                enable <= 1'b1;
                if (mode == ENCMP_PULSE) pulse_cnt <= width == '0 ? CW'(1) : width;
            end else begin
                if (clr_hit) enable <= 1'b0;
                if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - CW'(1);
            end
        end
    end
endmodule

// File: rtl/multi_enable_comparator.sv
// multi_enable_comparator: shadowed per-channel thresholds against a shared timebase count.
// Optional ENCMP_LOAD_GATE_EN: shadow loads at count==0 also require an armed update strobe.
module multi_enable_comparator
    import enable_comparator_pkg::*;
#(
    parameter int N_CHANNELS    = 4,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [COUNTER_WIDTH-1:0]            count,
    input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] thresholds,
    input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] widths,
    input  logic [2*N_CHANNELS-1:0]             modes,
`ifdef ENCMP_LOAD_GATE_EN
    input  logic                                update,
`endif
    output logic [N_CHANNELS-1:0]               enable_out,
    output logic                                shadow_loaded
);
    logic [COUNTER_WIDTH-1:0] thr_sh [N_CHANNELS];
    logic [COUNTER_WIDTH-1:0] wid_sh [N_CHANNELS];
    encmp_mode_e              mode_sh [N_CHANNELS];
    logic                     load;
`ifdef ENCMP_LOAD_GATE_EN
    logic armed;
    // An update coincident with count==0 loads immediately without arming
    assign load = count == '0 && (armed || update);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) armed <= 1'b0;
        else armed <= !load && (armed || update);
    end
`else
    assign load = count == '0;
`endif
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_loaded <= 1'b0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                thr_sh[i] <= '0;
                wid_sh[i] <= '0;
                mode_sh[i] <= ENCMP_OFF;
            end
        end else begin
            shadow_loaded <= load;
            if (load) begin
                for (int i = 0; i < N_CHANNELS; i++) begin
                    thr_sh[i] <= thresholds[i*COUNTER_WIDTH +: COUNTER_WIDTH];
                    wid_sh[i] <= widths[i*COUNTER_WIDTH +: COUNTER_WIDTH];
                    mode_sh[i] <= encmp_mode_e'(modes[i*ENCMP_MODE_WIDTH +: ENCMP_MODE_WIDTH]);
                end
            end
        end
    end
    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
        enable_channel #(.CW(COUNTER_WIDTH)) u_ch (
            .clock      (clock),
            .reset      (reset),
            .count      (count),
            .thr        (thr_sh[g]),
            .width      (wid_sh[g]),
            .mode       (mode_sh[g]),
            .mode_change(load && modes[g*ENCMP_MODE_WIDTH +: ENCMP_MODE_WIDTH] != mode_sh[g]),
            .enable     (enable_out[g])
        );
    end
endmodule
